param_ram_clr: RTL
==================

PARAM_RAM_CLR -- requirements
Module: param_ram_clr

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6: address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter RDW_MODE, default 0: same-address read-during-write policy; 0 = read-old, 1 = write-first.
REQ-004 clk  in  1  clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset; reset reset, synchronous, active-high; clock clk.
REQ-006 clr_req  in  1  single-cycle request to start a clear sweep.
REQ-007 wr_en  in  1  write strobe.
REQ-008 rd_en  in  1  read strobe.
REQ-009 addr  in  ADDR_W  shared read/write address.
REQ-010 din  in  DATA_W  write data.
REQ-011 be  in  DATA_W/8  byte-lane write enables; bit k gates din[8k+7:8k].
REQ-012 dout  out  DATA_W  registered read data.
REQ-013 rd_valid  out  1  pulses high for one cycle when dout carries new read data.
REQ-014 busy  out  1  high while a clear sweep runs.
REQ-015 clr_done  out  1  pulses high for one cycle on the last sweep write.

Function
REQ-016 The FSM SHALL have two states, IDLE and CLEAR; a clr_req sampled in IDLE SHALL move it to CLEAR.
REQ-017 In CLEAR: one word written to zero per cycle, addresses 0..2**ADDR_W-1 ascending, from an internal counter.
REQ-018 The sweep SHALL last exactly 2**ADDR_W cycles; the last write raises clr_done and returns to IDLE next cycle.
REQ-019 busy SHALL be high in every CLEAR cycle and low in IDLE.
REQ-020 In CLEAR: wr_en, rd_en and clr_req ignored, memory untouched by them, rd_valid stays 0, dout holds.
REQ-021 In IDLE: wr_en updates only lanes with be=1; other lanes keep old content; be=0 writes nothing.
REQ-022 Read latency SHALL be 1: rd_en at edge n -> dout and rd_valid=1 after edge n+1; dout holds until the next read.
REQ-023 wr_en and rd_en together, same address: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns merged post-write word, per lane.
REQ-024 Write and read are independent when the same-cycle strobes share no lane effect; reads never alter memory.
REQ-025 The address counter SHALL wrap from 2**ADDR_W-1 to 0 only on sweep exit.

Reset
REQ-026 reset SHALL set dout=0, rd_valid=0, clr_done=0, counter=0, and force state CLEAR (busy=1 the cycle after).
REQ-027 Reset-initiated sweep SHALL behave identically to a clr_req sweep (REQ-017..REQ-019).
REQ-028 reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-029 reset has priority over clr_req, wr_en and rd_en.

Structure
REQ-030 Shared package ram_pkg SHALL hold the state enum (IDLE, CLEAR) and RDW_MODE constants RDW_READ_OLD=0, RDW_WRITE_FIRST=1.
REQ-031 The storage array with byte-lane write and registered read SHALL be a sub-module ram_core; FSM, counter and port muxing stay in the top.

Verification
REQ-032 Reset 1 cycle, DATA_W=8, ADDR_W=6 -> busy high 64 cycles, clr_done pulses once on address 63, then reads of addrs 0, 31, 63 return 0x00.
REQ-033 Write 0xA5 to addr 5 and read addr 5 next cycle -> dout=0xA5 with rd_valid=1 one cycle after rd_en.
REQ-034 DATA_W=32: word 0x11223344 at addr 2, write 0xAABBCCDD with be=4'b0101 -> read gives 0x11BB33DD.
REQ-035 Addr 7 holds 0x10; write 0x20 with read, same cycle -> dout=0x10 when RDW_MODE=0, dout=0x20 when RDW_MODE=1.
REQ-036 clr_req, then wr_en 0xFF to addr 3 during sweep -> write ignored, post-sweep read of addr 3 returns 0x00, rd_valid never high during busy.
REQ-037 Reset asserted at sweep cycle 20 -> counter restarts at 0, busy stays high 64 more cycles, exactly one clr_done.

Source files
------------

// File: rtl/param_ram_clr_pkg.sv
// ram_pkg: types and constants shared by the clearable RAM slice.
//   state_t          : sweep controller states (IDLE, CLEAR)
//   RDW_READ_OLD     : same-address read during write returns the old word
//   RDW_WRITE_FIRST  : same-address read during write returns the merged new word
//   lanes()          : number of byte lanes for a given word width
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/param_ram_clr_if.sv
// param_ram_clr_if: request/response bundle of the clearable RAM.
//   master : drives clr_req, wr_en, rd_en, addr, din, be; observes results
//   slave  : the RAM side; returns dout, rd_valid, busy, clr_done
interface param_ram_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);

  logic                  clr_req;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     dout;
  logic                  rd_valid;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output clr_req, wr_en, rd_en, addr, din, be,
    input  dout, rd_valid, busy, clr_done
  );

  modport slave (
    input  clr_req, wr_en, rd_en, addr, din, be,
    output dout, rd_valid, busy, clr_done
  );

endinterface

// File: rtl/param_ram_clr_core.sv
// ram_core: byte-lane-writable storage with a registered read port.
//   clk, reset : clock and synchronous active-high reset (clears only rd_data)
//   wr_en, wr_addr, wr_data, wr_be : write port, wr_be[k] gates byte lane k
//   rd_en, rd_addr                 : read request, data appears after one edge
//   rd_data                        : registered read word, holds between reads
// Each byte lane is its own array so every lane maps onto a plain
// single-write-port memory.
module ram_core
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = RDW_READ_OLD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [lanes(DATA_W)-1:0] wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int LANES = lanes(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic same_addr;
  assign same_addr = wr_en && rd_en && (wr_addr == rd_addr);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          mem[wr_addr] <= wr_data[8*gi +: 8];
        end
      end

      // Write-first forwards the incoming byte only for lanes actually
      // being written; untouched lanes still return stored content.
      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= '0;
        end else if (rd_en) begin
          if (RDW_MODE == RDW_WRITE_FIRST && same_addr && wr_be[gi]) begin
            q_reg <= wr_data[8*gi +: 8];
          end else begin
            q_reg <= mem[rd_addr];
          end
        end
      end

      assign rd_data[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/param_ram_clr.sv
// param_ram_clr: RAM with byte-lane writes, 1-cycle registered reads and a
// hardware clear sweep that zeroes every word, one per cycle, ascending.
//   clk   : clock, rising edge
//   reset : synchronous active-high; also launches a clear sweep
//   bus   : slave side of param_ram_clr_if (clr_req, wr_en, rd_en, addr,
//           din, be in; dout, rd_valid, busy, clr_done out)
// While a sweep runs the user strobes are ignored and the sweep owns the
// write port; reads are blocked so dout holds and rd_valid stays low.
module param_ram_clr
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = RDW_READ_OLD
) (
  input  logic            clk,
  input  logic            reset,
  param_ram_clr_if.slave  bus
);

  localparam int                LANES     = lanes(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] PREV_ADDR = LAST_ADDR - 1'b1;

  state_t            state_reg;
  logic [ADDR_W-1:0] count_reg;
  logic              clr_done_reg;
  logic              rd_valid_reg;

  logic              sweeping;
  logic              core_wr_en;
  logic [ADDR_W-1:0] core_wr_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [LANES-1:0]  core_wr_be;
  logic              core_rd_en;
  logic [DATA_W-1:0] core_rd_data;

  assign sweeping = (state_reg == CLEAR);

  // Port muxing: the sweep takes the write port with all lanes enabled.
  assign core_wr_en   = !reset && (sweeping || bus.wr_en);
  assign core_wr_addr = sweeping ? count_reg : bus.addr;
  assign core_wr_data = sweeping ? '0 : bus.din;
  assign core_wr_be   = sweeping ? '1 : bus.be;
  assign core_rd_en   = !reset && !sweeping && bus.rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      count_reg    <= '0;
      clr_done_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= core_rd_en;
      clr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.clr_req) begin
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          if (count_reg == LAST_ADDR) begin
            count_reg <= '0;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
          // Raised one edge early so the pulse lines up with the cycle
          // that carries the final write.
          if (count_reg == PREV_ADDR) begin
            clr_done_reg <= 1'b1;
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  ram_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (core_wr_en),
    .wr_addr (core_wr_addr),
    .wr_data (core_wr_data),
    .wr_be   (core_wr_be),
    .rd_en   (core_rd_en),
    .rd_addr (bus.addr),
    .rd_data (core_rd_data)
  );

  assign bus.dout     = core_rd_data;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.busy     = sweeping;
  assign bus.clr_done = clr_done_reg;

endmodule
